// File: rtl/mc_control.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/writeback.
// Optional bne support is enabled with `define MC_CONTROL_BNE_EN.
module mc_control #(
  parameter int unsigned OPCODE_LENGTH = 6,
  parameter int unsigned ALU_OP_LENTH  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [OPCODE_LENGTH-1:0] opcode,
  input  logic                     mem_ready,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic                     i_or_d,
  output logic                     ir_write,
  output logic                     pc_write,
  output logic                     pc_write_cond,
  output logic                     branch_ne,
  output logic [1:0]               pc_source,
  output logic                     alu_src_a,
  output logic [1:0]               alu_src_b,
  output logic [ALU_OP_LENTH-1:0]  alu_op,
  output logic                     reg_dst,
  output logic                     mem_to_reg,
  output logic                     reg_write,
  output logic                     retire,
  output logic                     halt
);

  localparam logic [OPCODE_LENGTH-1:0] OP_RTYPE = OPCODE_LENGTH'(6'b000000);
  localparam logic [OPCODE_LENGTH-1:0] OP_LW    = OPCODE_LENGTH'(6'b100011);
  localparam logic [OPCODE_LENGTH-1:0] OP_SW    = OPCODE_LENGTH'(6'b101011);
  localparam logic [OPCODE_LENGTH-1:0] OP_BEQ   = OPCODE_LENGTH'(6'b000100);
  localparam logic [OPCODE_LENGTH-1:0] OP_J     = OPCODE_LENGTH'(6'b000010);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADDI  = OPCODE_LENGTH'(6'b001000);
  localparam logic [OPCODE_LENGTH-1:0] OP_ANDI  = OPCODE_LENGTH'(6'b001100);
  localparam logic [OPCODE_LENGTH-1:0] OP_ORI   = OPCODE_LENGTH'(6'b001101);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLTI  = OPCODE_LENGTH'(6'b001010);
`ifdef MC_CONTROL_BNE_EN
  localparam logic [OPCODE_LENGTH-1:0] OP_BNE   = OPCODE_LENGTH'(6'b000101);
`endif

  localparam logic [ALU_OP_LENTH-1:0] ALU_ADD = ALU_OP_LENTH'(3'b000);
  localparam logic [ALU_OP_LENTH-1:0] ALU_SUB = ALU_OP_LENTH'(3'b001);
  localparam logic [ALU_OP_LENTH-1:0] ALU_RTY = ALU_OP_LENTH'(3'b010);
  localparam logic [ALU_OP_LENTH-1:0] ALU_AND = ALU_OP_LENTH'(3'b011);
  localparam logic [ALU_OP_LENTH-1:0] ALU_OR  = ALU_OP_LENTH'(3'b100);
  localparam logic [ALU_OP_LENTH-1:0] ALU_SLT = ALU_OP_LENTH'(3'b101);

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    I_EXEC   = 4'd8,
    I_WB     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
`ifdef MC_CONTROL_BNE_EN
    BRANCH_NE = 4'd13,
`endif
    HALT     = 4'd12
  } state_e;

  typedef struct packed {
    logic                    mem_read;
    logic                    mem_write;
    logic                    i_or_d;
    logic                    ir_write;
    logic                    pc_write;
    logic                    pc_write_cond;
    logic                    branch_ne;
    logic [1:0]              pc_source;
    logic                    alu_src_a;
    logic [1:0]              alu_src_b;
    logic [ALU_OP_LENTH-1:0] alu_op;
    logic                    reg_dst;
    logic                    mem_to_reg;
    logic                    reg_write;
    logic                    retire;
    logic                    halt;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_c;
  ctrl_t  ctrl_out_c;

  // ALU operation for the immediate-arithmetic group
  function automatic logic [ALU_OP_LENTH-1:0] i_alu_op(input logic [OPCODE_LENGTH-1:0] op);
    logic [ALU_OP_LENTH-1:0] r;
    r = ALU_ADD;
    case (op)
      OP_ANDI: r = ALU_AND;
      OP_ORI:  r = ALU_OR;
      OP_SLTI: r = ALU_SLT;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctrl_c  = '0;
    case (state_q)
      FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = SRCB_FOUR;
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.pc_source = PCS_ALU;
        if (mem_ready) begin
          ctrl_c.ir_write = 1'b1;
          ctrl_c.pc_write = 1'b1;
          state_d         = DECODE;
        end
      end
      DECODE: begin
        // Speculatively compute the branch target into ALUOut
        ctrl_c.alu_src_b = SRCB_IMM4;
        ctrl_c.alu_op    = ALU_ADD;
        case (opcode)
          OP_RTYPE:                          state_d = R_EXEC;
          OP_LW, OP_SW:                      state_d = MEM_ADDR;
          OP_BEQ:                            state_d = BRANCH;
          OP_J:                              state_d = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = I_EXEC;
`ifdef MC_CONTROL_BNE_EN
          OP_BNE:                            state_d = BRANCH_NE;
`endif
          default:                           state_d = HALT;
        endcase
      end
      MEM_ADDR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALU_ADD;
        state_d          = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.i_or_d   = 1'b1;
        if (mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.retire     = 1'b1;
        state_d           = FETCH;
      end
      MEM_WR: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.i_or_d    = 1'b1;
        if (mem_ready) begin
          ctrl_c.retire = 1'b1;
          state_d       = FETCH;
        end
      end
      R_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_B;
        ctrl_c.alu_op    = ALU_RTY;
        state_d          = R_WB;
      end
      R_WB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.reg_dst   = 1'b1;
        ctrl_c.retire    = 1'b1;
        state_d          = FETCH;
      end
      I_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = i_alu_op(opcode);
        state_d          = I_WB;
      end
      I_WB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.retire    = 1'b1;
        state_d          = FETCH;
      end
      BRANCH: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_src_b     = SRCB_B;
        ctrl_c.alu_op        = ALU_SUB;
        ctrl_c.pc_source     = PCS_ALUOUT;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.retire        = 1'b1;
        state_d              = FETCH;
      end
`ifdef MC_CONTROL_BNE_EN
      BRANCH_NE: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_B;
        ctrl_c.alu_op    = ALU_SUB;
        ctrl_c.pc_source = PCS_ALUOUT;
        ctrl_c.branch_ne = 1'b1;
        ctrl_c.retire    = 1'b1;
        state_d          = FETCH;
      end
`endif
      JUMP: begin
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_source = PCS_JUMP;
        ctrl_c.retire    = 1'b1;
        state_d          = FETCH;
      end
      HALT: begin
        ctrl_c.halt = 1'b1;
        state_d     = HALT;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset suppresses every request and write in the cycle it is asserted
  assign ctrl_out_c = rst ? '0 : ctrl_c;

  assign mem_read      = ctrl_out_c.mem_read;
  assign mem_write     = ctrl_out_c.mem_write;
  assign i_or_d        = ctrl_out_c.i_or_d;
  assign ir_write      = ctrl_out_c.ir_write;
  assign pc_write      = ctrl_out_c.pc_write;
  assign pc_write_cond = ctrl_out_c.pc_write_cond;
  assign pc_source     = ctrl_out_c.pc_source;
  assign alu_src_a     = ctrl_out_c.alu_src_a;
  assign alu_src_b     = ctrl_out_c.alu_src_b;
  assign alu_op        = ctrl_out_c.alu_op;
  assign reg_dst       = ctrl_out_c.reg_dst;
  assign mem_to_reg    = ctrl_out_c.mem_to_reg;
  assign reg_write     = ctrl_out_c.reg_write;
  assign retire        = ctrl_out_c.retire;
  assign halt          = ctrl_out_c.halt;
  // Without bne support this field is never set, so the output is constant 0
  assign branch_ne     = ctrl_out_c.branch_ne;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: per-instruction expected control traces, table rows and random programs.
module tb_mc_control;

  logic       clk, rst, mem_ready;
  logic [5:0] opcode;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne;
  logic [1:0] pc_source, alu_src_b;
  logic       alu_src_a;
  logic [2:0] alu_op;
  logic       reg_dst, mem_to_reg, reg_write, retire, halt;

  mc_control #(.OPCODE_LENGTH(6), .ALU_OP_LENTH(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .retire(retire), .halt(halt)
  );

  typedef struct packed {
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst, mem_to_reg, reg_write, retire, halt;
  } outs_t;

  typedef struct packed {
    logic  rdy;
    outs_t o;
  } step_t;

  typedef struct {
    logic [5:0] op;
    int         fw;
    int         mw;
    int         lat;
  } vec_t;

  outs_t act;
  step_t trace[$];
  int    errors = 0;
  int    checks = 0;

  always_comb act = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne,
                     pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
                     retire, halt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_outs(input string name, input outs_t a, input outs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  task automatic push(input outs_t o, input logic rdy);
    step_t s;
    s.rdy = rdy;
    s.o   = o;
    trace.push_back(s);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected per-cycle controls for one instruction, straight from the instruction-class rules
  task automatic build(input logic [5:0] op, input int fw, input int mw, output bit halted);
    outs_t o;
    halted = 1'b0;
    trace.delete();
    o = '0; o.mem_read = 1'b1; o.alu_src_b = 2'b01;
    repeat (fw) push(o, 1'b0);
    o.ir_write = 1'b1; o.pc_write = 1'b1;
    push(o, 1'b1);
    o = '0; o.alu_src_b = 2'b11;
    push(o, rnd());
    case (op)
      6'b000000: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_op = 3'b010; push(o, rnd());
        o = '0; o.reg_write = 1'b1; o.reg_dst = 1'b1; o.retire = 1'b1; push(o, rnd());
      end
      6'b100011, 6'b101011: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; push(o, rnd());
        o = '0; o.i_or_d = 1'b1;
        if (op == 6'b100011) begin
          o.mem_read = 1'b1;
          repeat (mw) push(o, 1'b0);
          push(o, 1'b1);
          o = '0; o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.retire = 1'b1; push(o, rnd());
        end else begin
          o.mem_write = 1'b1;
          repeat (mw) push(o, 1'b0);
          o.retire = 1'b1;
          push(o, 1'b1);
        end
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        o.alu_op = (op == 6'b001100) ? 3'b011 : (op == 6'b001101) ? 3'b100 :
                   (op == 6'b001010) ? 3'b101 : 3'b000;
        push(o, rnd());
        o = '0; o.reg_write = 1'b1; o.retire = 1'b1; push(o, rnd());
      end
      6'b000100: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_op = 3'b001; o.pc_source = 2'b01;
        o.pc_write_cond = 1'b1; o.retire = 1'b1; push(o, rnd());
      end
`ifdef MC_CONTROL_BNE_EN
      6'b000101: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_op = 3'b001; o.pc_source = 2'b01;
        o.branch_ne = 1'b1; o.retire = 1'b1; push(o, rnd());
      end
`endif
      6'b000010: begin
        o = '0; o.pc_write = 1'b1; o.pc_source = 2'b10; o.retire = 1'b1; push(o, rnd());
      end
      default: begin
        o = '0; o.halt = 1'b1;
        repeat (20) push(o, rnd());
        halted = 1'b1;
      end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'($urandom);
    #1 check_outs("reset_cycle_zero", act, '0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drive one instruction (optionally truncated to nsteps) and return the retire cycle
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int nsteps,
                           output int lat);
    bit halted;
    int n;
    build(op, fw, mw, halted);
    n   = (nsteps > 0 && nsteps < trace.size()) ? nsteps : trace.size();
    lat = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) opcode = op;
      mem_ready = trace[i].rdy;
      #1 check_outs($sformatf("op=%b step=%0d", op, i), act, trace[i].o);
      if (act.retire && lat == 0) lat = i + 1;
    end
    if (halted) do_reset();
  endtask

  initial begin
    vec_t       tbl[11];
    logic [5:0] pool[12];
    int         lat;

    tbl[0]  = '{6'b000000, 0, 0, 4};
    tbl[1]  = '{6'b100011, 2, 3, 10};
    tbl[2]  = '{6'b101011, 0, 0, 4};
    tbl[3]  = '{6'b000100, 0, 0, 3};
    tbl[4]  = '{6'b000010, 0, 0, 3};
    tbl[5]  = '{6'b001101, 0, 0, 4};
    tbl[6]  = '{6'b001000, 1, 0, 5};
    tbl[7]  = '{6'b001100, 0, 0, 4};
    tbl[8]  = '{6'b001010, 2, 0, 6};
    tbl[9]  = '{6'b101011, 1, 2, 7};
    tbl[10] = '{6'b100011, 0, 0, 5};

    pool = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000,
             6'b001100, 6'b001101, 6'b001010, 6'b000101, 6'b111111, 6'b000000};

    rst = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;
    repeat (2) begin
      @(negedge clk);
      #1 check_outs("reset_hold_zero", act, '0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].fw, tbl[i].mw, 0, lat);
      check_int($sformatf("latency row %0d", i), lat, tbl[i].lat);
    end

    // Illegal opcode parks in HALT until reset, then a normal instruction follows
    run_instr(6'b111111, 0, 0, 0, lat);
    run_instr(6'b000000, 0, 0, 0, lat);
    check_int("latency after halt", lat, 4);

    // Reset while waiting in MEM_RD abandons the load
    run_instr(6'b100011, 0, 5, 5, lat);
    do_reset();
    run_instr(6'b001000, 0, 0, 0, lat);
    check_int("latency after abort", lat, 4);

    // bne: BRANCH_NE with the option, HALT without it
    run_instr(6'b000101, 0, 0, 0, lat);
`ifdef MC_CONTROL_BNE_EN
    check_int("latency bne", lat, 3);
`endif

    for (int k = 0; k < 60; k++) begin
      logic [5:0] op;
      op = pool[$urandom_range(0, 11)];
      if ($urandom_range(0, 15) == 0) op = 6'($urandom);
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 0, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
